// File: rtl/change_dispenser_if.sv
// Purpose: groups the payout request, hopper handshake and status signals of the change dispenser.
// Latency: none, wiring only.
// Backpressure: hopper_ready/hopper_ack carry the hopper's backpressure to the dispenser.
// Ports (slave view): coins[7:0], start, hopper_ready, hopper_ack in;
//   eject_dollar/quarter/dime/nickel, clear_credit, busy, done, error, remaining[7:0] out.
interface change_dispenser_if;
  logic [7:0] coins;
  logic       start;
  logic       hopper_ready;
  logic       hopper_ack;
  logic       eject_dollar;
  logic       eject_quarter;
  logic       eject_dime;
  logic       eject_nickel;
  logic       clear_credit;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] remaining;

  // master: the coin register / hopper side that drives requests and acks
  modport master (
    output coins, start, hopper_ready, hopper_ack,
    input  eject_dollar, eject_quarter, eject_dime, eject_nickel,
    input  clear_credit, busy, done, error, remaining
  );

  // slave: the dispenser itself
  modport slave (
    input  coins, start, hopper_ready, hopper_ack,
    output eject_dollar, eject_quarter, eject_dime, eject_nickel,
    output clear_credit, busy, done, error, remaining
  );
endinterface

// File: rtl/change_dispenser.sv
// Purpose: pays out a credit greedily as dollars, quarters, dimes and nickels through a coin hopper.
// Latency: per coin 1 SELECT cycle plus ISSUE cycles up to and including the ack; DONE adds 1 cycle.
// Backpressure: waits in SELECT while hopper_ready=0; gives up a coin after ACK_TIMEOUT cycles without ack.
// Ports: clk, reset (async active-low), io (change_dispenser_if.slave).
module change_dispenser #(
  parameter int ACK_TIMEOUT = 100
) (
  input logic            clk,
  input logic            reset,
  change_dispenser_if.slave io
);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

  // Last ISSUE cycle index; reaching it without an ack ends the payout.
  localparam logic [7:0] TMAX = 8'(ACK_TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] rem_r, rem_n;
  logic [7:0] cnt_r, cnt_n;
  logic [3:0] ej_r, ej_n;     // {dollar, quarter, dime, nickel}
  logic       clr_r, clr_n;
  logic       err_r, err_n;
  logic       busy_r, done_r;
  logic [3:0] pick;
  logic [7:0] issue_val;

  // Largest coin not exceeding the remaining credit; only used when rem_r >= 5.
  always_comb begin
    pick = 4'b0001;
    if (rem_r >= 8'd100)     pick = 4'b1000;
    else if (rem_r >= 8'd25) pick = 4'b0100;
    else if (rem_r >= 8'd10) pick = 4'b0010;
  end

  // Value of the coin currently being requested, decoded from the eject register.
  always_comb begin
    case (ej_r)
      4'b1000: issue_val = 8'd100;
      4'b0100: issue_val = 8'd25;
      4'b0010: issue_val = 8'd10;
      4'b0001: issue_val = 8'd5;
      default: issue_val = 8'd0;
    endcase
  end

  always_comb begin
    state_n = state;
    rem_n   = rem_r;
    cnt_n   = cnt_r;
    ej_n    = ej_r;
    clr_n   = 1'b0;
    err_n   = err_r;
    case (state)
      IDLE: begin
        if (io.start) begin
          err_n = 1'b0;
          if (io.coins != 8'd0) begin
            rem_n   = io.coins;
            clr_n   = 1'b1;
            state_n = SELECT;
          end else begin
            state_n = DONE;
          end
        end
      end
      SELECT: begin
        if (rem_r == 8'd0) begin
          state_n = DONE;
        end else if (rem_r < 8'd5) begin
          // Residue that no coin can pay stays visible in remaining.
          err_n   = 1'b1;
          state_n = DONE;
        end else if (io.hopper_ready) begin
          ej_n    = pick;
          cnt_n   = 8'd0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        // An ack on the final timeout cycle still counts as success.
        if (io.hopper_ack) begin
          rem_n   = rem_r - issue_val;
          ej_n    = 4'b0000;
          state_n = SELECT;
        end else if (cnt_r == TMAX) begin
          ej_n    = 4'b0000;
          err_n   = 1'b1;
          cnt_n   = 8'd0;
          state_n = DONE;
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        ej_n    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rem_r  <= 8'd0;
      cnt_r  <= 8'd0;
      ej_r   <= 4'b0000;
      clr_r  <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      rem_r  <= rem_n;
      cnt_r  <= cnt_n;
      ej_r   <= ej_n;
      clr_r  <= clr_n;
      err_r  <= err_n;
      // busy and done are registered copies of the state they describe.
      busy_r <= (state_n == SELECT) || (state_n == ISSUE);
      done_r <= (state_n == DONE);
    end
  end

  assign io.eject_dollar  = ej_r[3];
  assign io.eject_quarter = ej_r[2];
  assign io.eject_dime    = ej_r[1];
  assign io.eject_nickel  = ej_r[0];
  assign io.clear_credit  = clr_r;
  assign io.busy          = busy_r;
  assign io.done          = done_r;
  assign io.error         = err_r;
  assign io.remaining     = rem_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Purpose: directed bench for change_dispenser with an eject scoreboard and a simple hopper model.
// Latency: hopper acks a configurable number of cycles after each eject rises.
// Backpressure: hopper_ready is driven directly by the directed steps.
module tb_change_dispenser;

  typedef struct {
    logic [3:0] ej;
    logic [7:0] rem;
  } exp_t;

  logic clk;
  logic reset;
  change_dispenser_if io ();

  change_dispenser #(.ACK_TIMEOUT(100)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t pend;
  int   done_cnt = 0, clr_cnt = 0, busy_cnt = 0, eject_cnt = 0;
  int   hi_len = 0, last_len = 0;
  int   d0, c0, b0, e0;
  logic ack_en = 1'b1;
  int   ack_delay = 2;

  function automatic logic [3:0] ejv();
    return {io.eject_dollar, io.eject_quarter, io.eject_dime, io.eject_nickel};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_eject"}, 32'(ejv()), 0);
    check({tag, "_clear"}, 32'(io.clear_credit), 0);
    check({tag, "_busy"}, 32'(io.busy), 0);
    check({tag, "_done"}, 32'(io.done), 0);
    check({tag, "_error"}, 32'(io.error), 0);
    check({tag, "_remaining"}, 32'(io.remaining), 0);
  endtask

  task automatic start_pay(input logic [7:0] c);
    d0 = done_cnt; c0 = clr_cnt; b0 = busy_cnt; e0 = eject_cnt;
    io.coins = c;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
  endtask

  // Hopper model: acks once the eject has been high for ack_delay cycles.
  initial begin
    int hcnt;
    hcnt = 0;
    io.hopper_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_en && ejv() != 4'b0000) begin
        hcnt++;
        io.hopper_ack = (hcnt == ack_delay);
      end else begin
        hcnt = 0;
        io.hopper_ack = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each eject rise, checks remaining on each fall.
  initial begin
    logic [3:0] prev, cur;
    prev = 4'b0000;
    forever begin
      @(negedge clk);
      cur = ejv();
      if (io.done) done_cnt++;
      if (io.clear_credit) clr_cnt++;
      if (io.busy) busy_cnt++;
      if (cur != 4'b0000) begin
        tests++;
        assert ($onehot(cur) && io.busy) else begin
          fails++;
          $error("FAIL eject_onehot_busy: observed eject=%b busy=%b expected one-hot with busy=1", cur, io.busy);
        end
      end
      if (cur != 4'b0000 && prev == 4'b0000) begin
        eject_cnt++;
        hi_len = 0;
        tests++;
        assert (exp_q.size() > 0) else begin
          fails++;
          $error("FAIL unexpected_eject: observed eject=%b expected none", cur);
        end
        if (exp_q.size() > 0) begin
          pend = exp_q.pop_front();
          check("eject_coin", 32'(cur), 32'(pend.ej));
        end
      end
      if (cur != 4'b0000) hi_len++;
      if (cur == 4'b0000 && prev != 4'b0000) begin
        last_len = hi_len;
        check("remaining_after_coin", 32'(io.remaining), 32'(pend.rem));
      end
      prev = cur;
    end
  end

  initial begin
    reset = 1'b0;
    io.coins = 8'd0;
    io.start = 1'b0;
    io.hopper_ready = 1'b1;
    #3;
    check_all_zero("reset");
    tick();
    tick();
    reset = 1'b1;
    tick();

    // 140 cents: dollar, quarter, dime, nickel.
    exp_q.push_back('{4'b1000, 8'd40});
    exp_q.push_back('{4'b0100, 8'd15});
    exp_q.push_back('{4'b0010, 8'd5});
    exp_q.push_back('{4'b0001, 8'd0});
    start_pay(8'd140);
    wait_done("c140", 100);
    check("c140_queue_left", 32'(exp_q.size()), 0);
    check("c140_ejects", 32'(eject_cnt - e0), 4);
    check("c140_clear_pulses", 32'(clr_cnt - c0), 1);
    check("c140_error", 32'(io.error), 0);
    check("c140_remaining", 32'(io.remaining), 0);
    tick();
    tick();

    // Zero credit: done the cycle after start, nothing else.
    start_pay(8'd0);
    check("c0_done_now", 32'(io.done), 1);
    wait_done("c0", 5);
    tick();
    check("c0_ejects", 32'(eject_cnt - e0), 0);
    check("c0_clear", 32'(clr_cnt - c0), 0);
    check("c0_busy_cycles", 32'(busy_cnt - b0), 0);

    // 7 cents: one nickel then a 2-cent residue fault.
    exp_q.push_back('{4'b0001, 8'd2});
    start_pay(8'd7);
    wait_done("c7", 50);
    check("c7_ejects", 32'(eject_cnt - e0), 1);
    check("c7_error", 32'(io.error), 1);
    check("c7_remaining", 32'(io.remaining), 2);
    tick();
    tick();

    // 25 cents with the hopper not ready for 10 cycles.
    io.hopper_ready = 1'b0;
    exp_q.push_back('{4'b0100, 8'd0});
    start_pay(8'd25);
    check("c25_error_cleared", 32'(io.error), 0);
    for (int i = 0; i < 10; i++) begin
      check("c25_busy_wait", 32'(io.busy), 1);
      check("c25_no_eject", 32'(ejv()), 0);
      tick();
    end
    io.hopper_ready = 1'b1;
    tick();
    check("c25_quarter_rise", 32'(ejv()), 32'(4'b0100));
    wait_done("c25", 50);
    check("c25_remaining", 32'(io.remaining), 0);
    check("c25_error", 32'(io.error), 0);
    tick();
    tick();

    // 10 cents, hopper never acks: timeout.
    ack_en = 1'b0;
    exp_q.push_back('{4'b0010, 8'd10});
    start_pay(8'd10);
    wait_done("c10", 200);
    check("c10_eject_len", 32'(last_len), 100);
    check("c10_error", 32'(io.error), 1);
    check("c10_remaining", 32'(io.remaining), 10);
    check("c10_queue_left", 32'(exp_q.size()), 0);
    ack_en = 1'b1;
    tick();
    tick();
    start_pay(8'd0);
    check("next_start_clears_error", 32'(io.error), 0);
    wait_done("clr_err", 5);
    tick();
    tick();

    // 255 cents, reset during ISSUE, then a clean nickel payout.
    ack_delay = 50;
    exp_q.push_back('{4'b1000, 8'd0});
    start_pay(8'd255);
    for (int i = 0; i < 10; i++) begin
      if (ejv() != 4'b0000) break;
      tick();
    end
    check("c255_in_issue", 32'(ejv()), 32'(4'b1000));
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    reset = 1'b1;
    ack_delay = 2;
    tick();
    tick();
    tick();
    check("midreset_queue_left", 32'(exp_q.size()), 0);
    check("midreset_no_eject", 32'(ejv()), 0);
    exp_q.push_back('{4'b0001, 8'd0});
    start_pay(8'd5);
    wait_done("c5", 50);
    check("c5_ejects", 32'(eject_cnt - e0), 1);
    check("c5_clear", 32'(clr_cnt - c0), 1);
    check("c5_error", 32'(io.error), 0);
    check("c5_remaining", 32'(io.remaining), 0);
    check("c5_queue_left", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter ACK_TIMEOUT, default 100, is the maximum clock cycles to wait for hopper_ack per coin; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 coins  input  8  credit to pay out, unsigned cents, from the coin register.
REQ-005 start  input  1  request payout; sampled on rising clk in IDLE only.
REQ-006 hopper_ready  input  1  hopper can accept an eject command.
REQ-007 hopper_ack  input  1  hopper confirms the currently requested coin was ejected.
REQ-008 eject_dollar, eject_quarter, eject_dime, eject_nickel  output  1 each  one-hot eject request, registered.
REQ-009 clear_credit  output  1  one-cycle pulse telling the coin register to zero its credit.
REQ-010 busy  output  1  high while a payout is in progress.
REQ-011 done  output  1  one-cycle pulse at the end of every payout.
REQ-012 error  output  1  sticky fault flag, cleared on the next accepted start.
REQ-013 remaining  output  8  credit still to be paid, unsigned cents.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, SELECT, ISSUE, DONE.
REQ-015 IDLE: on start=1 with coins!=0, load remaining<=coins, pulse clear_credit, clear error, go SELECT.
REQ-016 IDLE: on start=1 with coins==0, clear error, go DONE with no clear_credit and no eject.
REQ-017 SELECT, remaining==0: go DONE.
REQ-018 SELECT, remaining 1..4: set error=1, go DONE; the residue stays in remaining.
REQ-019 SELECT, remaining>=5: choose the largest coin not exceeding remaining (100, 25, 10, 5).
  - hopper_ready=1: go ISSUE with only the chosen eject_* high from the next cycle.
  - hopper_ready=0: stay in SELECT indefinitely.
REQ-020 ISSUE: hold the chosen eject_* high and count cycles.
  - hopper_ack=1: on that edge subtract the coin value from remaining, drop eject_*, go SELECT.
REQ-021 ISSUE: if ACK_TIMEOUT cycles pass without hopper_ack, drop eject_*, set error=1, leave remaining unchanged, go DONE.
REQ-022 hopper_ack SHALL be ignored outside ISSUE.
REQ-023 DONE: done=1 for exactly one cycle, then go IDLE.
REQ-024 busy=1 in SELECT and ISSUE only.
REQ-025 At most one eject_* SHALL be high in any cycle; eject_* SHALL be high only in ISSUE.
REQ-026 remaining SHALL never underflow, because the coin choice guarantees remaining >= coin value.
REQ-027 start SHALL be ignored in SELECT, ISSUE and DONE.
REQ-028 Coin payout latency SHALL be: 1 SELECT cycle + ISSUE cycles up to and including the ack.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for clk, force all of the following:
  - state=IDLE;
  - remaining=0 and the timeout counter=0;
  - all eject_*, clear_credit, busy, done and error low.
REQ-030 reset asserted mid-payout SHALL abort with no further eject; operation SHALL resume normally on the first clk after reset returns high.

Verification
REQ-031 coins=140, start pulse, ready=1, ack 2 cycles after each eject ->
  - ejects: dollar, quarter, dime, nickel, in that order;
  - remaining: 40, 15, 5, 0;
  - one clear_credit pulse, one done pulse, error=0.
REQ-032 coins=0, start pulse -> done pulse 1 cycle later; no eject, no clear_credit, busy stays 0.
REQ-033 coins=7 -> one nickel ejected, remaining=2, error=1, done pulses.
REQ-034 coins=25, hopper_ready=0 for 10 cycles then 1 ->
  - no eject while ready=0, busy=1 throughout;
  - eject_quarter rises the cycle after ready rises.
REQ-035 coins=10, hopper_ack never asserted ->
  - eject_dime drops after ACK_TIMEOUT (100) cycles;
  - error=1, remaining=10, done pulses;
  - the next start clears error.
REQ-036 coins=255, reset=0 during ISSUE -> all outputs 0 asynchronously; after release, a new start with coins=5 ejects one nickel.
